// File: rtl/qcw_pkg.sv
// Shared types for the QCW burst scheduler.
// State encoding and default tick divider.
package qcw_pkg;

  localparam int QCW_TICK_DIV = 50;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FIRE      = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_COOLDOWN  = 3'd3,
    ST_FAULT     = 3'd4
  } qcw_state_e;

endpackage

// File: rtl/qcw_tick_gen.sv
// Free-running tick prescaler for the QCW scheduler.
// One-clock tick every DIV clocks; held at phase zero while clr.
module qcw_tick_gen #(
  parameter int DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = !clr && (r_cnt == LAST);

endmodule

// File: rtl/qcw_burst_scheduler.sv
// QCW burst scheduler: paces start requests to the bridge driver
// by period, cooldown and burst count, with timeout/fault handling.
module qcw_burst_scheduler
  import qcw_pkg::*;
#(
  parameter int TICK_DIV = QCW_TICK_DIV,
  parameter int CNT_W    = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] burst_count_i,
  input  logic [CNT_W-1:0] cooldown_i,
  input  logic [CNT_W-1:0] timeout_i,
  input  logic             clear_fault_i,
  input  logic             qcw_done_i,
  input  logic             qcw_fault_i,
  input  logic             qcw_halt_i,
  output logic             qcw_start_o,
  output logic             busy_o,
  output logic             fault_latched_o,
  output logic [CNT_W-1:0] bursts_done_o
);

  qcw_state_e r_state;
  qcw_state_e w_next;

  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_cool;
  logic [CNT_W-1:0] r_tmo;
  logic [CNT_W-1:0] r_per_cnt;
  logic [CNT_W-1:0] r_cd_cnt;
  logic [CNT_W-1:0] r_to_cnt;
  logic [CNT_W-1:0] r_bursts;

  logic             w_tick;
  logic             w_idle;
  logic [CNT_W-1:0] w_per_nx;
  logic [CNT_W-1:0] w_cd_nx;
  logic [CNT_W-1:0] w_to_nx;
  logic [CNT_W-1:0] w_per_min;
  logic [CNT_W-1:0] w_bursts_inc;
  logic             w_cd_ok;
  logic             w_to_hit;
  logic             w_last;
  logic             w_exit;
  logic             w_start_run;
  logic             w_done_hit;

  function automatic logic [CNT_W-1:0] f_sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             en
  );
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  assign w_idle = (r_state == ST_IDLE);

  qcw_tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .clr   (w_idle),
    .tick  (w_tick)
  );

  // Comparisons use the post-tick value so a tick can end a wait
  assign w_per_nx  = f_sat_inc(r_per_cnt, w_tick);
  assign w_cd_nx   = f_sat_inc(r_cd_cnt, w_tick);
  assign w_to_nx   = f_sat_inc(r_to_cnt, w_tick);
  assign w_per_min = (r_period == '0) ? CNT_W'(1) : r_period;

  assign w_cd_ok = (w_cd_nx >= r_cool)
                && (w_per_nx >= w_per_min);
  assign w_to_hit = (r_tmo != '0)
                 && (w_to_nx >= r_tmo);

  assign w_bursts_inc = f_sat_inc(r_bursts, 1'b1);
  assign w_last = (r_count != '0)
               && (w_bursts_inc == r_count);

  assign w_exit = (r_state == ST_COOLDOWN)
               && !qcw_fault_i
               && !qcw_halt_i
               && w_cd_ok;

  assign w_start_run = w_idle && enable_i;
  assign w_done_hit  = (r_state == ST_WAIT_DONE)
                    && qcw_done_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (enable_i) w_next = ST_FIRE;
      end
      ST_FIRE: begin
        if (qcw_fault_i)     w_next = ST_FAULT;
        else if (qcw_halt_i) w_next = ST_IDLE;
        else                 w_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (qcw_fault_i)     w_next = ST_FAULT;
        else if (qcw_halt_i) w_next = ST_IDLE;
        else if (w_to_hit)   w_next = ST_FAULT;
        else if (qcw_done_i) w_next = ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        if (qcw_fault_i)     w_next = ST_FAULT;
        else if (qcw_halt_i) w_next = ST_IDLE;
        else if (w_exit) begin
          w_next = (!enable_i || w_last) ? ST_IDLE : ST_FIRE;
        end
      end
      ST_FAULT: begin
        if (clear_fault_i && !enable_i) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    qcw_start_o     = 1'b0;
    busy_o          = 1'b1;
    fault_latched_o = 1'b0;
    unique case (r_state)
      ST_IDLE:  busy_o = 1'b0;
      ST_FIRE:  qcw_start_o = 1'b1;
      ST_FAULT: begin
        busy_o          = 1'b0;
        fault_latched_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_period <= '0;
      r_count  <= '0;
      r_cool   <= '0;
      r_tmo    <= '0;
      r_bursts <= '0;
    end else if (w_start_run) begin
      r_period <= period_i;
      r_count  <= burst_count_i;
      r_cool   <= cooldown_i;
      r_tmo    <= timeout_i;
      r_bursts <= '0;
    end else if (w_exit) begin
      r_bursts <= w_bursts_inc;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_per_cnt <= '0;
      r_cd_cnt  <= '0;
      r_to_cnt  <= '0;
    end else begin
      r_per_cnt <= (r_state == ST_FIRE) ? '0 : w_per_nx;
      r_to_cnt  <= (r_state == ST_FIRE) ? '0 : w_to_nx;
      r_cd_cnt  <= w_done_hit ? '0 : w_cd_nx;
    end
  end

  assign bursts_done_o = r_bursts;

endmodule
